// File: rtl/logic_op_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_op_pkg : op encodings and per-bit evaluator for logic_op_pipe  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  // Single-bit evaluator; the pipe replicates it across WIDTH so the function
  // stays width-agnostic.
  function automatic logic logic_op_eval(input logic a, input logic b, input op_e op);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_op_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_op_stage : one valid/ready register slice, payload width DW    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module logic_op_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // Ready is purely combinational so an empty-or-draining slice never bubbles.
  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      r_data  <= in_data;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/logic_op_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_op_pipe : two-stage c = f(a,b), d = a | (b ^ c) with valid/ready|
// | Optional output handshake counter: LOGIC_OP_PIPE_CNT_EN              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d
`ifdef LOGIC_OP_PIPE_CNT_EN
  ,
  output logic [15:0]      out_count
`endif
);

  logic [WIDTH-1:0]   w_c;
  logic [3*WIDTH-1:0] w_s1_data;
  logic               w_s1_valid;
  logic               w_s2_take;
  logic [WIDTH-1:0]   w_s1_a;
  logic [WIDTH-1:0]   w_s1_b;
  logic [WIDTH-1:0]   w_s1_c;
  logic [WIDTH-1:0]   w_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_c[i] = logic_op_eval(in_a[i], in_b[i], op_e'(in_op));
  end

  logic_op_stage #(.DW(3*WIDTH)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_a, in_b, w_c}),
    .out_valid (w_s1_valid),
    .out_ready (w_s2_take),
    .out_data  (w_s1_data)
  );

  assign {w_s1_a, w_s1_b, w_s1_c} = w_s1_data;
  assign w_d = w_s1_a | (w_s1_b ^ w_s1_c);

  logic_op_stage #(.DW(2*WIDTH)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s2_take),
    .in_data   ({w_s1_c, w_d}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_c, out_d})
  );

`ifdef LOGIC_OP_PIPE_CNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign out_count = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_op_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_logic_op_pipe : scoreboard bench for logic_op_pipe (WIDTH=8)      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_logic_op_pipe;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [1:0]       in_op = 2'd0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
`ifdef LOGIC_OP_PIPE_CNT_EN
  logic [15:0]      out_count;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb_q[$];
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_d     (out_d)
`ifdef LOGIC_OP_PIPE_CNT_EN
    ,
    .out_count (out_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: {c, d}
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
    logic [7:0] c;
    case (op)
      2'd0:    c = a & b;
      2'd1:    c = a | b;
      2'd2:    c = a ^ b;
      default: c = ~(a & b);
    endcase
    return {c, a | (b ^ c)};
  endfunction

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_c", 32'(out_c), 32'(e[15:8]));
          chk("sb_d", 32'(out_d), 32'(e[7:0]));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_a, in_b, in_op));
      if (prev_stall && !out_valid) chk("valid_hold", 32'd0, 32'd1);
    end
    prev_stall = out_valid && !out_ready && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_c", 32'(out_c), 32'd0);
    chk("rst_d", 32'(out_d), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
  endtask

  logic [7:0] exp_c[4];
  logic [7:0] exp_d[4];

  initial begin
    exp_c = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    exp_d = '{8'hFC, 8'hF0, 8'hF0, 8'hF3};

    tick();
    do_reset();

    // Per-op results and latency
    for (int op = 0; op < 4; op++) begin
      in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_op = 2'(op); out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_early", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("op_c", 32'(out_c), 32'(exp_c[op]));
      chk("op_d", 32'(out_d), 32'(exp_d[op]));
      tick();
    end

    // Streaming, XOR of complements
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = 8'(i); in_b = ~8'(i); in_op = 2'd2; out_ready = 1'b1;
      @(negedge clk);
      chk("stream_ready", 32'(in_ready), 32'd1);
      if (i >= 2) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_c", 32'(out_c), 32'hFF);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stream_tail", 32'(out_valid), 32'd1);
      tick();
    end
    drain();

    // Backpressure: two buffered, third waits
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'(8'h11 * (i + 1)); in_b = 8'h5A; in_op = 2'(i);
      @(negedge clk);
      chk("bp_ready", 32'(in_ready), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk);
    chk("bp_still_blocked", 32'(in_ready), 32'd0);
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    drain();

    // Simultaneous accept/drain with op changing every beat
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_op = 2'(i % 4);
      out_ready = 1'b1;
      @(negedge clk);
      chk("sim_ready", 32'(in_ready), 32'd1);
      if (i >= 2) chk("sim_no_bubble", 32'(out_valid), 32'd1);
      tick();
    end
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h0F; in_op = 2'd3;
      tick();
    end
    @(negedge clk);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    do_reset();
    in_valid = 1'b1; in_a = 8'h69; in_b = 8'hC3; in_op = 2'd1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_d", 32'(out_d), 32'(8'h69 | (8'hC3 ^ (8'h69 | 8'hC3))));
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 2'($urandom);
      tick();
    end
    drain();

`ifdef LOGIC_OP_PIPE_CNT_EN
    do_reset();
    in_op = 2'd0; out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_valid = 1'b1; in_a = 8'(i); in_b = 8'(i >> 8);
      tick();
    end
    drain();
    chk("count_wrap", 32'(out_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("count_rst", 32'(out_count), 32'd0);
    tick();
`endif

    chk("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
